// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS core constants (next-PC source encoding, NOP) and fetch FSM state type.
package mips_pkg;
  localparam logic [2:0] PCSRC_PLUS4 = 3'd0;
  localparam logic [2:0] PCSRC_BT = 3'd1;
  localparam logic [2:0] PCSRC_JT = 3'd2;
  localparam logic [2:0] PCSRC_JR = 3'd3;
  localparam logic [31:0] INSTR_NOP = 32'h0;
  typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_e;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding register for a fetched word and its PC+4.
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  output logic        full_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o
);
  logic full_q, full_d;
  logic [31:0] instr_q, pc_plus4_q;
  always_comb full_d = clear_i ? 1'b0 : load_i ? 1'b1 : drain_i ? 1'b0 : full_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      instr_q <= INSTR_NOP;
      pc_plus4_q <= '0;
    end else begin
      full_q <= full_d;
      if (load_i) begin
        instr_q <= instr_i;
        pc_plus4_q <= pc_plus4_i;
      end
    end
  end
  assign full_o = full_q;
  assign instr_o = instr_q;
  assign pc_plus4_o = pc_plus4_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch with one outstanding imem request, redirects and a skid buffer.
// Define FETCH_ALIGN_CHK_EN to flag misaligned redirect targets on misalign_err_o.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic [2:0]  pc_src_sel_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] jump_target_i,
  input  logic [31:0] jr_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc_plus4_o,
  output logic        misalign_err_o
);
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, req_pc4_q, req_pc4_d, raw_target, target;
  logic redirect, deliver, issue, buf_load, buf_drain, buf_full;
  logic [31:0] buf_instr, buf_pc4;
  logic ifv_q, ifv_d;
  logic [31:0] ifi_q, ifi_d, ifp_q, ifp_d;
  assign redirect = (pc_src_sel_i == PCSRC_JT) | (pc_src_sel_i == PCSRC_JR) |
                    ((pc_src_sel_i == PCSRC_BT) & branch_taken_i);
  assign raw_target = (pc_src_sel_i == PCSRC_BT) ? branch_target_i :
                      (pc_src_sel_i == PCSRC_JT) ? jump_target_i : jr_target_i;
  assign target = raw_target & ~32'h3;
  // A returning word goes straight to IF/ID unless stalled (buffer) or redirected (dropped).
  assign deliver = (state_q == WAIT) & imem_rvalid_i & !stall_i & !redirect;
  assign buf_load = (state_q == WAIT) & imem_rvalid_i & stall_i & !redirect;
  assign buf_drain = buf_full & !stall_i & !redirect;
  assign issue = rst_ni & !buf_full & (deliver | ((state_q == IDLE) & !stall_i & !redirect));
  fetch_skid_buf u_skid (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (redirect),
    .load_i    (buf_load),
    .drain_i   (buf_drain),
    .instr_i   (imem_rdata_i),
    .pc_plus4_i(req_pc4_q),
    .full_o    (buf_full),
    .instr_o   (buf_instr),
    .pc_plus4_o(buf_pc4)
  );
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = issue ? WAIT : IDLE;
      WAIT:    state_d = !imem_rvalid_i ? (redirect ? DROP : WAIT) : (issue ? WAIT : IDLE);
      DROP:    state_d = imem_rvalid_i ? IDLE : DROP;
      default: state_d = IDLE;
    endcase
    pc_d = redirect ? target : issue ? pc_q + 32'd4 : pc_q;
    req_pc4_d = issue ? pc_q + 32'd4 : req_pc4_q;
    ifv_d = redirect ? 1'b0 : (deliver | buf_drain) ? 1'b1 : stall_i ? ifv_q : 1'b0;
    ifi_d = redirect ? INSTR_NOP : deliver ? imem_rdata_i : buf_drain ? buf_instr :
            stall_i ? ifi_q : INSTR_NOP;
    ifp_d = redirect ? 32'h0 : deliver ? req_pc4_q : buf_drain ? buf_pc4 :
            stall_i ? ifp_q : 32'h0;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      req_pc4_q <= '0;
      ifv_q <= 1'b0;
      ifi_q <= INSTR_NOP;
      ifp_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_pc4_q <= req_pc4_d;
      ifv_q <= ifv_d;
      ifi_q <= ifi_d;
      ifp_q <= ifp_d;
    end
  end
  assign imem_req_o = issue;
  assign imem_addr_o = pc_q;
  assign if_id_valid_o = ifv_q;
  assign if_id_instr_o = ifi_q;
  assign if_id_pc_plus4_o = ifp_q;
`ifdef FETCH_ALIGN_CHK_EN
  logic misalign_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) misalign_q <= 1'b0;
    else if (redirect && raw_target[1:0] != 2'b00) misalign_q <= 1'b1;
  end
  assign misalign_err_o = misalign_q;
`else
  assign misalign_err_o = 1'b0;
`endif
endmodule
